// File: rtl/sha2_pkg.sv
// sha2_pkg
// Shared types and constants for the SHA-2 compression datapath.
//   state_t     : sequencing states of the round controller
//   ROUNDS_256  : compression rounds per block for SHA-256
//   ROUNDS_512  : compression rounds per block for SHA-512
//   SHA256_IV   : initial hash value H0..H7 loaded by the Hash_Register
//   SHA256_K    : round constants K[0..63] selected by the round index
package sha2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha2_round_counter.sv
// sha2_round_counter
// Round index counter with terminal-count detect. Counts 0..ROUNDS-1 and
// wraps to 0 after the terminal round.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, count -> 0
//   clear : synchronous clear to 0 (wins over en)
//   en    : advance the count by one
//   count : current round index
//   tc    : high while count == ROUNDS-1
module sha2_round_counter #(
  parameter int ROUNDS = 64,
  parameter int RW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  output logic [RW-1:0] count,
  output logic          tc
);

  // Terminal round: the next advance wraps back to round 0 so the counter is
  // already zeroed when the following block starts.
  assign tc = (count == RW'(ROUNDS - 1));

  // Round register: clear has priority so an abort always lands on round 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + RW'(1);
    end
  end

endmodule

// File: rtl/sha256_round_controller.sv
// sha256_round_controller
// Sequencing FSM for the SHA-256 compression datapath. Accepts one 512-bit
// block per handshake, runs ROUNDS compression rounds on it, folds the
// working registers back into the hash, and after the last block of a
// message presents the digest until the consumer acknowledges it.
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   blk_valid    : block available from the message scheduler
//   blk_last     : block is the final one of its message (with blk_valid)
//   blk_ready    : controller accepts a block this cycle
//   abort        : synchronous discard of the current message
//   msg_init     : scheduler loads W[0..15] from the accepted block
//   hash_init    : Hash_Register loads the IV (first block of a message)
//   work_load    : a..h <= H
//   work_en      : a..h advance one round
//   round        : current round index t for K[t]/W[t] selection
//   hash_we      : H <= H + a..h
//   digest_valid : H holds the final digest
//   digest_ack   : consumer has taken the digest
module sha256_round_controller
  import sha2_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_256,
  parameter int RW     = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blk_valid,
  input  logic          blk_last,
  output logic          blk_ready,
  input  logic          abort,
  output logic          msg_init,
  output logic          hash_init,
  output logic          work_load,
  output logic          work_en,
  output logic [RW-1:0] round,
  output logic          hash_we,
  output logic          digest_valid,
  input  logic          digest_ack
);

  state_t        state;
  state_t        next_state;
  logic          first;
  logic          first_d;
  logic          last_q;
  logic          last_d;
  logic          cnt_clear;
  logic          cnt_en;
  logic [RW-1:0] cnt_value;
  logic          cnt_tc;

  sha2_round_counter #(
    .ROUNDS (ROUNDS),
    .RW     (RW)
  ) u_round_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (cnt_value),
    .tc    (cnt_tc)
  );

  // State and message flags. 'first' marks that the next accepted block
  // starts a new message and must reload the IV; 'last_q' remembers whether
  // the block in flight closes its message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      first  <= 1'b1;
      last_q <= 1'b0;
    end else begin
      state  <= next_state;
      first  <= first_d;
      last_q <= last_d;
    end
  end

  // Next-state and strobe decode. Strobes are Moore on the state except
  // msg_init/hash_init, which fire on the IDLE handshake itself. While reset
  // is held everything stays low, so blk_ready only rises once reset drops.
  // An abort outside IDLE zeroes every output in that cycle, which is what
  // keeps a pending hash_we from reaching the Hash_Register.
  always_comb begin
    next_state   = state;
    first_d      = first;
    last_d       = last_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    blk_ready    = 1'b0;
    msg_init     = 1'b0;
    hash_init    = 1'b0;
    work_load    = 1'b0;
    work_en      = 1'b0;
    hash_we      = 1'b0;
    digest_valid = 1'b0;
    round        = '0;
    if (reset) begin
      next_state = IDLE;
    end else if (abort && (state != IDLE)) begin
      next_state = IDLE;
      first_d    = 1'b1;
      cnt_clear  = 1'b1;
    end else begin
      round = cnt_value;
      case (state)
        IDLE: begin
          blk_ready = 1'b1;
          if (blk_valid) begin
            msg_init   = 1'b1;
            hash_init  = first;
            last_d     = blk_last;
            next_state = LOAD;
          end
        end
        LOAD: begin
          work_load  = 1'b1;
          cnt_clear  = 1'b1;
          next_state = ROUND;
        end
        ROUND: begin
          work_en = 1'b1;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
            next_state = UPDATE;
          end
        end
        UPDATE: begin
          hash_we    = 1'b1;
          first_d    = 1'b0;
          next_state = last_q ? DONE : IDLE;
        end
        DONE: begin
          digest_valid = 1'b1;
          if (digest_ack) begin
            first_d    = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_controller.sv
// tb_sha256_round_controller
// Randomised and directed stimulus against a schedule-level reference model.
// The model tracks only "idle / N cycles since acceptance / digest pending"
// and derives every expected strobe from the block schedule.
module tb_sha256_round_controller;
  import sha2_pkg::*;

  localparam int R = ROUNDS_256;
  localparam int W = $clog2(R);

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;
  logic         abort;
  logic         msg_init;
  logic         hash_init;
  logic         work_load;
  logic         work_en;
  logic [W-1:0] round;
  logic         hash_we;
  logic         digest_valid;
  logic         digest_ack;
  logic [W+6:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: m_off < 0 means idle, otherwise cycles since the
  // accepting edge (1 = LOAD cycle); m_done means a digest is pending.
  int m_off;
  bit m_done;
  bit m_first;
  bit m_last;

  always #5 clk = ~clk;

  assign obs = {blk_ready, msg_init, hash_init, work_load, work_en,
                hash_we, digest_valid, round};

  sha256_round_controller #(.ROUNDS(R), .RW(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .abort        (abort),
    .msg_init     (msg_init),
    .hash_init    (hash_init),
    .work_load    (work_load),
    .work_en      (work_en),
    .round        (round),
    .hash_we      (hash_we),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack)
  );

  task automatic checkOutput(input string tag, input logic [W+6:0] got,
                             input logic [W+6:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (rdy,mi,hi,wl,we,hw,dv,round) at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [W+6:0] modelOut(input bit v, input bit ab);
    logic         r, mi, hi, wl, we, hw, dv;
    logic [W-1:0] rd;
    {r, mi, hi, wl, we, hw, dv} = '0;
    rd = '0;
    if (m_done) begin
      dv = !ab;
    end else if (m_off < 0) begin
      r  = 1'b1;
      mi = v;
      hi = v && m_first;
    end else if (!ab) begin
      wl = (m_off == 1);
      we = (m_off >= 2) && (m_off <= R + 1);
      if (we) rd = W'(m_off - 2);
      hw = (m_off == R + 2);
    end
    return {r, mi, hi, wl, we, hw, dv, rd};
  endfunction

  task automatic modelReset();
    m_off   = -1;
    m_done  = 1'b0;
    m_first = 1'b1;
    m_last  = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit l, input bit ab, input bit ak);
    if (m_done) begin
      if (ab || ak) begin
        m_done  = 1'b0;
        m_first = 1'b1;
      end
    end else if (m_off < 0) begin
      if (v) begin
        m_off  = 1;
        m_last = l;
      end
    end else if (ab) begin
      m_off   = -1;
      m_first = 1'b1;
    end else if (m_off == R + 2) begin
      m_first = 1'b0;
      m_off   = -1;
      m_done  = m_last;
    end else begin
      m_off++;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance.
  task automatic applyStimulus(input bit v, input bit l, input bit ab,
                               input bit ak, input string tag);
    blk_valid  = v;
    blk_last   = l;
    abort      = ab;
    digest_ack = ak;
    #1;
    checkOutput(tag, obs, modelOut(v, ab));
    @(posedge clk);
    modelStep(v, l, ab, ak);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    blk_valid  = 1'b0;
    blk_last   = 1'b0;
    abort      = 1'b0;
    digest_ack = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", obs, '0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, "idle_ready");

    // Single last block, blk_valid left high throughout the run.
    applyStimulus(1, 1, 0, 0, "s1_accept");
    for (int i = 0; i < R + 2; i++) applyStimulus(1, 0, 0, 0, "s1_run");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "s1_done_wait");
    applyStimulus(0, 0, 0, 1, "s1_ack");
    applyStimulus(0, 0, 0, 0, "s1_idle");

    // Two-block message: IV load only on the first acceptance.
    applyStimulus(1, 0, 0, 0, "s2_accept0");
    for (int i = 0; i < R + 8 && m_off >= 0; i++) applyStimulus(0, 0, 0, 0, "s2_run0");
    applyStimulus(1, 1, 0, 0, "s2_accept1");
    for (int i = 0; i < R + 8 && !m_done; i++) applyStimulus(0, 0, 0, 0, "s2_run1");
    applyStimulus(0, 0, 0, 1, "s2_ack");

    // Abort at round 30, then an abort in IDLE alongside a valid block.
    applyStimulus(1, 0, 0, 0, "ab_accept");
    for (int i = 0; i < R && m_off < 32; i++) applyStimulus(0, 0, 0, 0, "ab_run");
    applyStimulus(0, 0, 1, 0, "ab_abort");
    applyStimulus(1, 1, 1, 0, "ab_idle_accept");
    for (int i = 0; i < R + 8 && !m_done; i++) applyStimulus(0, 0, 0, 0, "ab_run2");
    applyStimulus(0, 0, 0, 1, "ab_ack");

    // Asynchronous reset at round 10.
    applyStimulus(1, 1, 0, 0, "rst_accept");
    for (int i = 0; i < R && m_off < 12; i++) applyStimulus(0, 0, 0, 0, "rst_run");
    blk_valid = 1'b1;
    reset     = 1'b1;
    #1;
    checkOutput("async_reset", obs, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, "rst_release");

    // Ack held high the whole time: digest_valid lasts one cycle only.
    applyStimulus(1, 1, 0, 1, "ack_accept");
    for (int i = 0; i < R + 6; i++) applyStimulus(0, 0, 0, 1, "ack_held");

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(bit'($urandom % 2), bit'(($urandom % 3) == 0),
                    bit'(($urandom % 100) == 0), bit'(($urandom % 4) == 0),
                    "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
